// File: rtl/hex_counter_display_pkg.sv
// Shared definitions for the hex counter display.
// Provides the 16-entry active-low seven-segment table (bit0=a ... bit6=g)
// and a ceiling-log2 helper used to size the prescaler tick counter.
package hex_counter_display_pkg;

    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Number of bits needed to hold values 0..value-1 (returns 0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned remaining;
        result    = 0;
        remaining = (value > 0) ? value - 1 : 0;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hex_counter_display_hex_to_seven_seg.sv
// Combinational hex digit to active-low seven-segment decoder.
// Ports:
//   value    - 4-bit hex digit
//   segments - active-low segments, bit0=a ... bit6=g
module hex_to_seven_seg
    import hex_counter_display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] segments
);

    assign segments = SEG_PATTERNS[value];

endmodule

// File: rtl/hex_counter_display.sv
// Up/down counter with load, programmable modulus, wrap/saturate mode,
// clock-enable prescaler and a terminal-count pulse, driving DIGITS
// active-low seven-segment hex digits.
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous active-high reset
//   enable     - count enable, gates prescaler and stepping
//   up         - 1 = count up, 0 = count down
//   load       - synchronous parallel load strobe (beats enable)
//   load_value - value to load, clamped to MAX_COUNT
//   Q          - registered count
//   tc         - registered one-cycle pulse for each step taken from a bound
//   HEX        - active-low segments, digit i at HEX[7*i+6:7*i]
module hex_counter_display
    import hex_counter_display_pkg::*;
#(
    parameter int unsigned     DIGITS    = 4,
    parameter longint unsigned MAX_COUNT = (64'd1 << (4 * DIGITS)) - 64'd1,
    parameter int unsigned     PRESCALE  = 1,
    parameter bit              SATURATE  = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] MAX_Q = W'(MAX_COUNT);

    logic [W-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic         step;

    // Prescaler: a step fires on the enabled edge that closes a full period.
    if (PRESCALE > 1) begin : g_prescale
        localparam int unsigned TW = clog2(PRESCALE);
        localparam logic [TW-1:0] TICK_LAST = TW'(PRESCALE - 1);

        logic [TW-1:0] tick_q, tick_d;

        always_comb begin
            tick_d = tick_q;
            if (load) begin
                tick_d = '0;
            end else if (enable) begin
                tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                tick_q <= '0;
            end else begin
                tick_q <= tick_d;
            end
        end

        assign step = enable && !load && (tick_q == TICK_LAST);
    end else begin : g_no_prescale
        assign step = enable && !load;
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_value > MAX_Q) ? MAX_Q : load_value;
        end else if (step) begin
            if (up) begin
                if (count_q == MAX_Q) begin
                    tc_d = 1'b1;
                    if (!SATURATE) count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
                    if (!SATURATE) count_d = MAX_Q;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign Q  = count_q;
    assign tc = tc_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        hex_to_seven_seg u_seg (
            .value    (count_q[4*i +: 4]),
            .segments (HEX[7*i +: 7])
        );
    end

endmodule

// File: tb/tb_hex_counter_display.sv
// Directed self-checking bench: three configurations share one set of inputs;
// each test phase checks only the instance it targets.
module tb_hex_counter_display;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        up;
    logic        load;
    logic [15:0] load_value;

    logic [15:0] q0, q2;
    logic [7:0]  q1;
    logic        tc0, tc1, tc2;
    logic [27:0] hex0, hex2;
    logic [13:0] hex1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    // Default: 4 digits, full 16-bit range, wrap, no prescale.
    hex_counter_display u_dut0 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .Q          (q0),
        .tc         (tc0),
        .HEX        (hex0)
    );

    // Two digits, modulus 60, saturating.
    hex_counter_display #(
        .DIGITS    (2),
        .MAX_COUNT (59),
        .SATURATE  (1'b1)
    ) u_dut1 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up         (up),
        .load       (load),
        .load_value (load_value[7:0]),
        .Q          (q1),
        .tc         (tc1),
        .HEX        (hex1)
    );

    // Four digits, prescale by 4.
    hex_counter_display #(
        .PRESCALE (4)
    ) u_dut2 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .Q          (q2),
        .tc         (tc2),
        .HEX        (hex2)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        up         = 1'b1;
        load       = 1'b0;
        load_value = '0;

        // 1: reset state, then 20 up steps.
        do_reset();
        check_val("t1 reset q", q0, 16'h0000);
        check_val("t1 reset tc", tc0, 1'b0);
        check_val("t1 reset hex", hex0, {4{7'b1000000}});
        enable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            check_val("t1 tc low", tc0, 1'b0);
        end
        check_val("t1 q", q0, 16'h0014);
        check_val("t1 hex0", hex0[6:0], 7'b0011001);
        check_val("t1 hex1", hex0[13:7], 7'b1111001);

        // 2: load near top and wrap up.
        load       = 1'b1;
        load_value = 16'hFFFE;
        tick(1);
        load = 1'b0;
        check_val("t2 load q", q0, 16'hFFFE);
        check_val("t2 load tc", tc0, 1'b0);
        tick(1);
        check_val("t2 q max", q0, 16'hFFFF);
        check_val("t2 tc max", tc0, 1'b0);
        tick(1);
        check_val("t2 q wrap", q0, 16'h0000);
        check_val("t2 tc wrap", tc0, 1'b1);

        // 3: wrap down from zero, then load beats enable.
        up = 1'b0;
        tick(1);
        check_val("t3 q down wrap", q0, 16'hFFFF);
        check_val("t3 tc down wrap", tc0, 1'b1);
        load       = 1'b1;
        load_value = 16'h1234;
        tick(1);
        load = 1'b0;
        check_val("t3 load q", q0, 16'h1234);
        check_val("t3 load tc", tc0, 1'b0);
        check_val("t3 hex", hex0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        enable = 1'b0;
        tick(1);
        check_val("t3 hold q", q0, 16'h1234);
        check_val("t3 hold tc", tc0, 1'b0);

        // 4: modulus 60 saturating instance.
        do_reset();
        load       = 1'b1;
        load_value = 16'h0057;
        tick(1);
        load = 1'b0;
        check_val("t4 clamp q", q1, 8'd59);
        check_val("t4 clamp tc", tc1, 1'b0);
        check_val("t4 hex", hex1, {7'b0110000, 7'b0000011});
        enable = 1'b1;
        up     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_val("t4 sat q", q1, 8'd59);
            check_val("t4 sat tc", tc1, 1'b1);
        end
        enable = 1'b0;
        tick(1);
        check_val("t4 idle tc", tc1, 1'b0);
        load       = 1'b1;
        load_value = 16'h0000;
        tick(1);
        load   = 1'b0;
        up     = 1'b0;
        enable = 1'b1;
        tick(1);
        check_val("t4 sat low q", q1, 8'd0);
        check_val("t4 sat low tc", tc1, 1'b1);
        up = 1'b1;
        tick(1);
        check_val("t4 resume q", q1, 8'd1);
        check_val("t4 resume tc", tc1, 1'b0);

        // 5: prescale by 4.
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        up     = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            check_val("t5 q", q2, 16'(e / 4));
            check_val("t5 tc", tc2, 1'b0);
        end
        tick(2);
        check_val("t5 mid q", q2, 16'd3);
        enable = 1'b0;
        tick(5);
        check_val("t5 pause q", q2, 16'd3);
        enable = 1'b1;
        tick(1);
        check_val("t5 resume1 q", q2, 16'd3);
        tick(1);
        check_val("t5 resume2 q", q2, 16'd4);

        // 6: reset mid-period discards the partial prescale count.
        load       = 1'b1;
        load_value = 16'h00A7;
        tick(1);
        load = 1'b0;
        tick(2);
        check_val("t6 pre q", q2, 16'h00A7);
        do_reset();
        check_val("t6 reset q", q2, 16'h0000);
        check_val("t6 reset tc", tc2, 1'b0);
        check_val("t6 reset hex", hex2, {4{7'b1000000}});
        tick(3);
        check_val("t6 third q", q2, 16'h0000);
        tick(1);
        check_val("t6 fourth q", q2, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hex_counter_display.md
Name: hex_counter_display

Overview:
Parametrised up/down counter driving active-low seven-segment hex digits. It is the next generation of the lab 16-bit toggle counter. It adds digit-count generalisation, direction control, parallel load, a programmable modulus, wrap or saturate mode, a clock-enable prescaler and a terminal-count pulse. It sits between board inputs (KEY/SW) and the HEX outputs in the top-level instantiation wrapper.

Parameters:
DIGITS, 4, number of hex digits displayed; counter width W = 4*DIGITS
MAX_COUNT, 2**(4*DIGITS)-1, largest legal count value (modulus-1); must be >= 1
PRESCALE, 1, number of enabled clock cycles per count step; 1 means step every enabled cycle
SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  count enable (the old "toggle"); gates the prescaler and stepping
up  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load strobe
load_value  input  W  value loaded when load=1
Q  output  W  current count, registered
tc  output  1  terminal-count pulse, registered, one cycle wide per bound event
HEX  output  7*DIGITS  segments; digit i occupies HEX[7*i+6:7*i] and shows Q[4*i+3:4*i]; active-low, bit0=a ... bit6=g

Behaviour:
- Reset: synchronous, checked only on the rising edge of clock. On reset: Q=0, tc=0, prescaler tick counter=0. HEX then shows all zeros (7'b1000000 per digit).
- Priority per edge: reset > load > step > hold.
- load=1: Q <= min(load_value, MAX_COUNT); tick counter cleared; tc <= 0. The load takes effect whatever the values of enable and up.
- Prescaler: tick counter runs 0..PRESCALE-1. It increments only while enable=1 and load=0, and wraps to 0. A step occurs on the edge where enable=1 and tick==PRESCALE-1. When enable=0, tick holds its value. When PRESCALE=1, every enabled edge is a step and the tick counter has no logic.
- Step, up=1: if Q<MAX_COUNT then Q<=Q+1. If Q==MAX_COUNT: Q<=0 when SATURATE=0, Q holds when SATURATE=1.
- Step, down=0: if Q>0 then Q<=Q-1. If Q==0: Q<=MAX_COUNT when SATURATE=0, Q holds when SATURATE=1.
- tc: goes to 1 for the cycle after any step taken from a bound in the current direction (MAX going up, 0 going down), whether the counter wraps or saturates. tc is 0 otherwise, including non-step cycles. In saturate mode, repeated steps at the bound give one tc pulse per step.
- Changing direction: up is sampled on each step edge, so a direction change takes effect on the next step with no lost or extra step.
- Latency: Q updates 1 edge after a step condition. tc is aligned with the Q update (both are registered on the same edge). HEX is combinational from Q, with 0 extra cycles.
- Non-power-of-2 modulus: Q never exceeds MAX_COUNT. Values A-F appear on HEX only if MAX_COUNT allows them.
- Reset asserted while a prescale period is in progress: the partial period is discarded and the next step needs a full PRESCALE enabled cycles.

Decomposition:
- Shared package/header: the 16-entry active-low seven-segment pattern constants, including 0=7'b1000000, 1=7'b1111001, 8=7'b0000000 and F=7'b0001110. Also a clog2 helper for sizing the tick counter.
- One natural sub-module, hex_to_seven_seg (4-bit in, 7-bit active-low out, purely combinational). It is instantiated DIGITS times in a generate loop.
- Counter, prescaler and tc logic stay in the parent.

Test Plan:
1. Defaults, reset pulse, then enable=1, up=1 for 20 cycles -> Q=0x0014 and HEX0=7'b0011001 (digit 4). HEX1 shows 1 (7'b1111001). tc=0 throughout.
2. load=1 with load_value=0xFFFE, then enable=1, up=1 for 2 cycles -> Q steps 0xFFFF, then 0x0000. tc=1 only in the cycle Q becomes 0x0000.
3. Set up=0 at Q=0x0000 with enable=1 -> Q=0xFFFF next edge and tc pulses. Then load=1 and enable=1 on the same edge with load_value=0x1234 -> Q=0x1234, and the load wins.
4. DIGITS=2, MAX_COUNT=59, SATURATE=1, load_value=0x57 (87) -> Q clamps to 59. Counting up 3 more steps -> Q stays 59, with tc high on each of those 3 cycles.
5. PRESCALE=4, enable=1 for 12 cycles -> Q=3, stepping on edges 4, 8 and 12. Drop enable for 5 cycles after edge 2 of a period -> the tick resumes from 2, and the next step comes 2 enabled edges later.
6. Assert reset mid-count at Q=0x00A7 with PRESCALE=4 and tick=2 -> Q=0, tc=0 and HEX all 7'b1000000. The first step after release comes on the 4th enabled edge.
